wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of pending-write entries (power of two, >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: R  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: alu_valid  input  1  ALU result present this cycle.
REQ-005 SHALL have port: alu_adr  input  5  ALU destination register.
REQ-006 SHALL have port: alu_data  input  32  ALU result value.
REQ-007 SHALL have port: ld_valid  input  1  load result present this cycle.
REQ-008 SHALL have port: ld_adr  input  5  load destination register.
REQ-009 SHALL have port: ld_data  input  32  load result value.
REQ-010 SHALL have port: rdy  output  1  high when at least 2 entries are free.
REQ-011 SHALL have port: W  output  1  register-bank write strobe, registered.
REQ-012 SHALL have port: AdrC  output  5  register-bank write address, registered.
REQ-013 SHALL have port: C  output  32  register-bank write data, registered.
REQ-014 SHALL have port: AdrA, AdrB  input  5 each  bypass lookup addresses.
REQ-015 SHALL have port: hitA, hitB  output  1 each  lookup matched a pending write.
REQ-016 SHALL have port: fwdA, fwdB  output  32 each  youngest pending data for the lookup.
REQ-017 SHALL have port: ovf  output  1  sticky: a request arrived while rdy was low.

Function
REQ-018 SHALL hold a circular FIFO of DEPTH entries {adr, data} with read/write pointers wrapping modulo DEPTH and a 0..DEPTH occupancy count.
REQ-019 SHALL drop, without enqueuing, any request whose address is 0 (register $zero).
REQ-020 SHALL, when both valids are high in one cycle, enqueue the load entry first (older), then the ALU entry.
REQ-021 SHALL enqueue only when rdy is high at the clock edge; a valid request with rdy low SHALL be discarded and ovf set until reset.
REQ-022 SHALL pop at most one entry per cycle whenever the FIFO is non-empty, loading it into AdrC/C and asserting W for exactly one cycle per entry.
REQ-023 SHALL produce W high in the cycle immediately after the enqueueing edge when the FIFO was empty (1-cycle latency).
REQ-024 SHALL keep W low, and AdrC/C at their previous values, while the FIFO is empty.
REQ-025 SHALL update occupancy as count + enq - deq (enq in 0..2) on simultaneous enqueue and dequeue; no entry lost or duplicated.
REQ-026 SHALL drive rdy combinationally from count <= DEPTH-2.
REQ-027 SHALL compute hitA/fwdA combinationally over all FIFO entries plus the AdrC/C register while W is high; the youngest match wins; the AdrC/C register is oldest.
REQ-028 SHALL drive hitX=0 and fwdX=0 when AdrX is 0 or no match exists; same-cycle incoming requests SHALL NOT be searched.
REQ-029 SHALL drain entries in exact enqueue order, so later writes to one register always reach the register bank after earlier ones.

Reset
REQ-030 SHALL, on R low, immediately and asynchronously clear the count and pointers, and force W=0, AdrC=0, C=0, ovf=0, hitA=hitB=0.
REQ-031 SHALL discard all pending entries on reset mid-operation; no W pulse SHALL occur for them after R returns high.
REQ-032 SHALL accept requests from the first rising edge on which R is high.

Verification
REQ-033 Single ALU write adr=5 data=0x12345678 into empty queue -> next cycle W=1, AdrC=5, C=0x12345678; following cycle W=0.
REQ-034 Same cycle ld (adr=3, 0xAAAA0000) and alu (adr=3, 0x0000BBBB) -> W pulses two consecutive cycles, first C=0xAAAA0000 then C=0x0000BBBB; in between, AdrA=3 gives hitA=1, fwdA=0x0000BBBB.
REQ-035 Dual writes every cycle until rdy=0 (DEPTH=4) -> rdy low at count 3 or 4, no entry lost, pointers wrap, all writes emerge in order; one extra request while rdy=0 -> ovf=1, entry absent.
REQ-036 ALU write with adr=0 -> no W pulse, hitA=0 for AdrA=0.
REQ-037 Assert R low with 3 entries pending -> W=0 immediately, no further W pulses, rdy=1, ovf=0 after release.

Source files
------------

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : wb_queue
//  Purpose  : Register-bank write-back queue. Merges ALU and load results into
//             an in-order circular FIFO, drains one entry per cycle into a
//             registered write port, and offers a youngest-wins bypass lookup
//             over every write still pending.
//  Revision : 1.0  initial release
// ============================================================================
module wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        R,
   input  logic        alu_valid,
   input  logic [4:0]  alu_adr,
   input  logic [31:0] alu_data,
   input  logic        ld_valid,
   input  logic [4:0]  ld_adr,
   input  logic [31:0] ld_data,
   output logic        rdy,
   output logic        W,
   output logic [4:0]  AdrC,
   output logic [31:0] C,
   input  logic [4:0]  AdrA,
   input  logic [4:0]  AdrB,
   output logic        hitA,
   output logic        hitB,
   output logic [31:0] fwdA,
   output logic [31:0] fwdB,
   output logic        ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_RDY_MAX = CW'(DEPTH - 2);

   // Entry storage (no reset needed: validity is tracked by the pointers/count)
   logic [4:0]    adr_q  [DEPTH];
   logic [31:0]   data_q [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          W_q, W_d;
   logic [4:0]    AdrC_q, AdrC_d;
   logic [31:0]   C_q, C_d;
   logic          ovf_q, ovf_d;

   logic          w_rdy;
   logic          w_ld_en;
   logic          w_alu_en;
   logic [1:0]    w_n_enq;
   logic          w_deq;
   logic [4:0]    w_first_adr;
   logic [31:0]   w_first_data;
   logic [PW-1:0] w_wslot1;
   logic [PW-1:0] w_slot;

   assign w_rdy    = (count_q <= C_RDY_MAX);
   assign w_wslot1 = wptr_q + PW'(1);

   // Enqueue/dequeue decisions and next-state for pointers, count and write port.
   // Every accepted request is written into storage; when the queue is empty the
   // oldest incoming request is also forwarded straight to the write port and the
   // read pointer steps over its slot, giving a one-cycle empty-queue latency.
   always_comb begin
      w_ld_en      = ld_valid  && (ld_adr  != 5'd0) && w_rdy;
      w_alu_en     = alu_valid && (alu_adr != 5'd0) && w_rdy;
      w_n_enq      = {1'b0, w_ld_en} + {1'b0, w_alu_en};
      w_first_adr  = w_ld_en ? ld_adr  : alu_adr;
      w_first_data = w_ld_en ? ld_data : alu_data;
      w_deq        = (count_q != '0) || (w_n_enq != 2'd0);

      count_d = count_q + CW'(w_n_enq) - CW'(w_deq);
      wptr_d  = wptr_q + PW'(w_n_enq);
      rptr_d  = rptr_q + PW'(w_deq);
      ovf_d   = ovf_q | ((ld_valid | alu_valid) & ~w_rdy);

      W_d    = w_deq;
      AdrC_d = AdrC_q;
      C_d    = C_q;
      if (count_q != '0) begin
         AdrC_d = adr_q[rptr_q];
         C_d    = data_q[rptr_q];
      end else if (w_n_enq != 2'd0) begin
         AdrC_d = w_first_adr;
         C_d    = w_first_data;
      end
   end

   // Control state and registered write port, cleared asynchronously.
   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         W_q     <= 1'b0;
         AdrC_q  <= 5'd0;
         C_q     <= 32'd0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         W_q     <= W_d;
         AdrC_q  <= AdrC_d;
         C_q     <= C_d;
         ovf_q   <= ovf_d;
      end
   end

   // Entry writes: load goes first (older), ALU takes the following slot.
   always_ff @(posedge clk) begin
      if (w_ld_en) begin
         adr_q[wptr_q]  <= ld_adr;
         data_q[wptr_q] <= ld_data;
      end
      if (w_alu_en) begin
         adr_q[w_ld_en ? w_wslot1 : wptr_q]  <= alu_adr;
         data_q[w_ld_en ? w_wslot1 : wptr_q] <= alu_data;
      end
   end

   // Bypass lookup: write-port register is oldest, then FIFO oldest to youngest,
   // so a later match overrides an earlier one. Register $zero never hits.
   always_comb begin
      hitA   = 1'b0;
      fwdA   = 32'd0;
      hitB   = 1'b0;
      fwdB   = 32'd0;
      w_slot = '0;
      if (W_q && (AdrC_q == AdrA) && (AdrA != 5'd0)) begin
         hitA = 1'b1;
         fwdA = C_q;
      end
      if (W_q && (AdrC_q == AdrB) && (AdrB != 5'd0)) begin
         hitB = 1'b1;
         fwdB = C_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         w_slot = rptr_q + PW'(i);
         if ((CW'(i) < count_q) && (adr_q[w_slot] == AdrA) && (AdrA != 5'd0)) begin
            hitA = 1'b1;
            fwdA = data_q[w_slot];
         end
         if ((CW'(i) < count_q) && (adr_q[w_slot] == AdrB) && (AdrB != 5'd0)) begin
            hitB = 1'b1;
            fwdB = data_q[w_slot];
         end
      end
   end

   assign rdy  = w_rdy;
   assign W    = W_q;
   assign AdrC = AdrC_q;
   assign C    = C_q;
   assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_queue
//  Purpose  : Directed self-checking bench for wb_queue with an expected-write
//             scoreboard and a small occupancy model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  adr;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        R   = 1'b0;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_adr   = 5'd0;
   logic [31:0] alu_data  = 32'd0;
   logic        ld_valid  = 1'b0;
   logic [4:0]  ld_adr    = 5'd0;
   logic [31:0] ld_data   = 32'd0;
   logic [4:0]  AdrA = 5'd0;
   logic [4:0]  AdrB = 5'd0;
   logic        rdy, W, hitA, hitB, ovf;
   logic [4:0]  AdrC;
   logic [31:0] C, fwdA, fwdB;

   ent_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cnt_m = 0;
   bit          ovf_m = 1'b0;
   logic [4:0]  last_adr  = 5'd0;
   logic [31:0] last_data = 32'd0;

   wb_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .R(R),
      .alu_valid(alu_valid), .alu_adr(alu_adr), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_adr(ld_adr), .ld_data(ld_data),
      .rdy(rdy), .W(W), .AdrC(AdrC), .C(C),
      .AdrA(AdrA), .AdrB(AdrB), .hitA(hitA), .hitB(hitB),
      .fwdA(fwdA), .fwdB(fwdB), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock of stimulus: drive at negedge, update model, check after posedge.
   task automatic step(input bit lv, input logic [4:0] la, input logic [31:0] ldd,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad);
      int   n;
      bit   deq;
      ent_t e;
      @(negedge clk);
      ld_valid = lv;  ld_adr = la;  ld_data = ldd;
      alu_valid = av; alu_adr = aa; alu_data = ad;
      n = 0;
      if (cnt_m <= DEPTH - 2) begin
         if (lv && la != 5'd0) begin sb.push_back('{la, ldd}); n++; end
         if (av && aa != 5'd0) begin sb.push_back('{aa, ad});  n++; end
      end else if (lv || av) begin
         ovf_m = 1'b1;
      end
      deq   = (cnt_m > 0) || (n > 0);
      cnt_m = cnt_m + n - (deq ? 1 : 0);
      @(posedge clk);
      #1;
      ld_valid  = 1'b0;
      alu_valid = 1'b0;
      chk("W", W, deq);
      if (deq && sb.size() > 0) begin
         e = sb.pop_front();
         chk("AdrC", AdrC, e.adr);
         chk("C", C, e.data);
         last_adr  = e.adr;
         last_data = e.data;
      end else begin
         chk("AdrC_hold", AdrC, last_adr);
         chk("C_hold", C, last_data);
      end
      chk("rdy", rdy, (cnt_m <= DEPTH - 2));
      chk("ovf", ovf, ovf_m);
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      // Reset state
      AdrA = 5'd5; AdrB = 5'd5;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_W", W, 1'b0);
      chk("rst_AdrC", AdrC, 5'd0);
      chk("rst_C", C, 32'd0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_rdy", rdy, 1'b1);
      chk("rst_hitA", hitA, 1'b0);
      chk("rst_hitB", hitB, 1'b0);
      @(negedge clk);
      R = 1'b1;

      // Single ALU write into empty queue: W next cycle, bypass from write port
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234_5678);
      AdrA = 5'd5; #1;
      chk("hitA_portreg", hitA, 1'b1);
      chk("fwdA_portreg", fwdA, 32'h1234_5678);
      idle();

      // Dual write to same register: load first, youngest wins in lookup
      step(1'b1, 5'd3, 32'hAAAA_0000, 1'b1, 5'd3, 32'h0000_BBBB);
      AdrA = 5'd3; AdrB = 5'd7; #1;
      chk("hitA_young", hitA, 1'b1);
      chk("fwdA_young", fwdA, 32'h0000_BBBB);
      chk("hitB_miss", hitB, 1'b0);
      chk("fwdB_miss", fwdB, 32'd0);
      AdrA = 5'd0; #1;
      chk("hitA_zero", hitA, 1'b0);
      chk("fwdA_zero", fwdA, 32'd0);
      idle();
      idle();

      // Write to $zero is dropped
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
      AdrA = 5'd0; #1;
      chk("hitA_r0", hitA, 1'b0);
      idle();

      // Fill with dual writes until not ready, then one rejected request
      for (int i = 0; i < 3; i++)
         step(1'b1, 5'(10 + i), $urandom, 1'b1, 5'(20 + i), $urandom);
      chk("rdy_full", rdy, 1'b0);
      step(1'b1, 5'd30, 32'hCAFE_0001, 1'b1, 5'd31, 32'hCAFE_0002);
      AdrA = 5'd30; AdrB = 5'd31; #1;
      chk("hitA_rejected", hitA, 1'b0);
      chk("hitB_rejected", hitB, 1'b0);
      repeat (5) idle();
      chk("drain_empty", sb.size(), 0);

      // Reset with three entries pending
      for (int i = 0; i < 3; i++)
         step(1'b1, 5'(12 + i), $urandom, 1'b1, 5'(24 + i), $urandom);
      #2;
      R = 1'b0;
      AdrA = 5'd26; #1;
      chk("mid_rst_W", W, 1'b0);
      chk("mid_rst_AdrC", AdrC, 5'd0);
      chk("mid_rst_C", C, 32'd0);
      chk("mid_rst_ovf", ovf, 1'b0);
      chk("mid_rst_rdy", rdy, 1'b1);
      chk("mid_rst_hitA", hitA, 1'b0);
      sb.delete();
      cnt_m = 0; ovf_m = 1'b0; last_adr = 5'd0; last_data = 32'd0;
      @(negedge clk);
      R = 1'b1;
      repeat (4) idle();

      // Accepts again right after reset release
      step(1'b1, 5'd9, 32'h0909_0909, 1'b0, 5'd0, 32'd0);
      idle();
      chk("final_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
